// File: rtl/des_result_fifo.sv
// Capture FIFO for the pipelined DES core: accepts 64-bit blocks with no backpressure
// and drains them as 32-bit words (high half first) over a valid/ready handshake.
module des_result_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_dv,
  input  logic [63:0]             i_ciphertext,
  output logic [31:0]             o_word,
  output logic                    o_word_valid,
  input  logic                    i_word_ready,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_overflow,
  input  logic                    i_clr_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  phase_e           phase_q, phase_d;
  logic             ovf_q, ovf_d;

  logic             empty_c;
  logic             full_c;
  logic             xfer_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [63:0]      rd_entry_c;

  // A full FIFO still accepts a block when the head entry leaves in the same cycle.
  assign empty_c = (level_q == '0);
  assign full_c  = (level_q == LVL_FULL);
  assign xfer_c  = !empty_c && i_word_ready;
  assign pop_c   = xfer_c && (phase_q == PH_LO);
  assign push_c  = i_dv && (!full_c || pop_c);
  assign drop_c  = i_dv && full_c && !pop_c;

  // Next-state for pointers, level, word phase and the sticky overflow flag.
  always_comb begin
    phase_d  = phase_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (xfer_c) begin
      case (phase_q)
        PH_HI:   phase_d = PH_LO;
        PH_LO:   phase_d = PH_HI;
        default: phase_d = PH_HI;
      endcase
    end

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (i_clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q  <= PH_HI;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= i_ciphertext;
    end
  end

  assign rd_entry_c = mem_q[rd_ptr_q];

  always_comb begin
    o_word = 32'h0;
    if (!empty_c) begin
      o_word = (phase_q == PH_LO) ? rd_entry_c[31:0] : rd_entry_c[63:32];
    end
  end

  assign o_word_valid = !empty_c;
  assign o_level      = level_q;
  assign o_empty      = empty_c;
  assign o_full       = full_c;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_des_result_fifo.sv
// Bench for des_result_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_des_result_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              dv;
  logic [63:0]       ct;
  logic [31:0]       word;
  logic              word_valid;
  logic              rdy;
  logic [LVL_W-1:0]  level;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              clr;

  int total = 0;
  int bad   = 0;

  des_result_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dv           (dv),
    .i_ciphertext   (ct),
    .o_word         (word),
    .o_word_valid   (word_valid),
    .i_word_ready   (rdy),
    .o_level        (level),
    .o_empty        (empty),
    .o_full         (full),
    .o_overflow     (ovf),
    .i_clr_overflow (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of whole blocks, the half currently shown, and the sticky flag.
  bit [63:0] mq[$];
  bit        mphase = 1'b0;
  bit        movf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mphase = 1'b0;
      movf   = 1'b0;
    end else begin
      bit was_full, xfer, pop, push, drop;
      was_full = (mq.size() == DEPTH);
      xfer = (mq.size() != 0) && rdy;
      pop  = xfer && mphase;
      push = dv && (!was_full || pop);
      drop = dv && was_full && !pop;
      if (xfer) mphase = ~mphase;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ct);
      if (drop) movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit [63:0] head;
    bit [31:0] exp_word;
    exp_word = 32'h0;
    if (mq.size() != 0) begin
      head = mq[0];
      exp_word = mphase ? head[31:0] : head[63:32];
    end
    chk("word",  64'(word),       64'(exp_word));
    chk("valid", 64'(word_valid), 64'(mq.size() != 0));
    chk("level", 64'(level),      64'(mq.size()));
    chk("empty", 64'(empty),      64'(mq.size() == 0));
    chk("full",  64'(full),       64'(mq.size() == DEPTH));
    chk("ovf",   64'(ovf),        64'(movf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit [63:0] blk [17];
  bit [63:0] nb;

  initial begin
    rst_n = 1'b0; dv = 1'b0; ct = '0; rdy = 1'b0; clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf",   64'(ovf), 64'd0);
    chk("rst_word",  64'(word), 64'd0);

    // Single block, first-word fall-through
    dv = 1'b1; ct = 64'h958313539316391d; rdy = 1'b1;
    step();
    dv = 1'b0;
    chk("single_hi", 64'(word), 64'h95831353);
    chk("single_valid", 64'(word_valid), 64'd1);
    step();
    chk("single_lo", 64'(word), 64'h9316391d);
    step();
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_level", 64'(level), 64'd0);

    // Backpressure
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blk[i] = {$urandom, $urandom};
      dv = 1'b1; ct = blk[i];
      step();
    end
    dv = 1'b0;
    repeat (10) step();
    chk("bp_level", 64'(level), 64'd3);
    chk("bp_hold", 64'(word), 64'(blk[0][63:32]));
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hi", 64'(word), 64'(blk[i][63:32]));
      step();
      chk("bp_lo", 64'(word), 64'(blk[i][31:0]));
      step();
    end
    chk("bp_empty", 64'(empty), 64'd1);

    // Fill and overflow
    rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      blk[i] = {$urandom, $urandom};
      dv = 1'b1; ct = blk[i];
      step();
      if (i == 15) begin
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_noovf", 64'(ovf), 64'd0);
      end
    end
    dv = 1'b0;
    chk("fill_ovf", 64'(ovf), 64'd1);
    chk("fill_level", 64'(level), 64'd16);
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_hi", 64'(word), 64'(blk[i][63:32]));
      step();
      chk("drain_lo", 64'(word), 64'(blk[i][31:0]));
      step();
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_ovf_sticky", 64'(ovf), 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 64'(ovf), 64'd0);

    // Full with simultaneous pop
    rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dv = 1'b1; ct = {$urandom, $urandom};
      step();
    end
    dv = 1'b0; rdy = 1'b1;
    step();
    nb = {$urandom, $urandom};
    dv = 1'b1; ct = nb;
    step();
    dv = 1'b0;
    chk("fp_level", 64'(level), 64'd16);
    chk("fp_ovf", 64'(ovf), 64'd0);
    repeat (30) step();
    chk("fp_last_hi", 64'(word), 64'(nb[63:32]));
    step();
    chk("fp_last_lo", 64'(word), 64'(nb[31:0]));
    step();
    chk("fp_empty", 64'(empty), 64'd1);

    // Streaming at full input rate against half-rate drain
    rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      dv = 1'b1; ct = {$urandom, $urandom};
      step();
    end
    dv = 1'b0;
    chk("stream_ovf", 64'(ovf), 64'd1);
    repeat (40) step();
    chk("stream_empty", 64'(empty), 64'd1);

    // Asynchronous reset at level 5, phase 1
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      blk[i] = {$urandom, $urandom};
      dv = 1'b1; ct = blk[i];
      step();
    end
    dv = 1'b0; rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("ar_pre_lo", 64'(word), 64'(blk[0][31:0]));
    chk("ar_pre_level", 64'(level), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(word_valid), 64'd0);
    chk("ar_level", 64'(level), 64'd0);
    chk("ar_ovf", 64'(ovf), 64'd0);
    step();
    rst_n = 1'b1;
    nb = {$urandom, $urandom};
    dv = 1'b1; ct = nb; rdy = 1'b1;
    step();
    dv = 1'b0;
    chk("ar_new_hi", 64'(word), 64'(nb[63:32]));
    step();
    chk("ar_new_lo", 64'(word), 64'(nb[31:0]));
    step();
    chk("ar_empty", 64'(empty), 64'd1);

    // Randomized mixed traffic
    for (int i = 0; i < 3000; i++) begin
      dv  = ($urandom_range(0, 99) < 55);
      rdy = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 99) < 5);
      ct  = {$urandom, $urandom};
      step();
    end
    dv = 1'b0; clr = 1'b0; rdy = 1'b1;
    repeat (40) step();
    chk("final_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
